// File: rtl/adder_prefix_pipe.sv
// Pipelined Kogge-Stone adder/subtractor.
// Elastic valid/ready handshake on both sides.
// Sum and flags are decoded combinationally from the last stage register.
module adder_prefix_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic             zero_o,
    output logic             neg_o
);

    localparam int unsigned LVLS = $clog2(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] g;      // group generate, carry-in folded into bit 0
        logic [WIDTH-1:0] p;      // group propagate
        logic [WIDTH-1:0] po;     // per-bit propagate, needed for the final sum
        logic             c0;     // effective carry into bit 0
        logic             a_msb;  // operand A sign bit, for overflow
    } stage_t;

    // Apply prefix levels [lo, hi) to a generate/propagate set.
    function automatic stage_t prefix_levels(input stage_t x,
                                             input int unsigned lo,
                                             input int unsigned hi);
        stage_t           y;
        logic [WIDTH-1:0] g_prev;
        logic [WIDTH-1:0] p_prev;
        int unsigned      d;
        y = x;
        for (int unsigned lvl = 0; lvl < LVLS; lvl++) begin
            if (lvl >= lo && lvl < hi) begin
                d      = 32'(1) << lvl;
                g_prev = y.g;
                p_prev = y.p;
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    if (i >= d) begin
                        y.g[i] = g_prev[i] | (p_prev[i] & g_prev[i-d]);
                        y.p[i] = p_prev[i] & p_prev[i-d];
                    end
                end
            end
        end
        return y;
    endfunction

    logic [WIDTH-1:0]  bx_c;
    stage_t            prep_c;
    stage_t            nxt_c [STAGES];
    stage_t            st_q  [STAGES];
    stage_t            st_d  [STAGES];
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [STAGES-1:0] vin_c;
    logic [STAGES:0]   rdy_c;
    stage_t            last_c;
    logic [WIDTH-1:0]  sum_c;
    logic              unused_p;

    // Operand preparation: invert B and carry for subtract, fold carry-in into g[0].
    always_comb begin
        prep_c       = '0;
        bx_c         = sub_i ? ~b_i : b_i;
        prep_c.c0    = sub_i ? ~cin_i : cin_i;
        prep_c.g     = a_i & bx_c;
        prep_c.p     = a_i ^ bx_c;
        prep_c.po    = prep_c.p;
        prep_c.g[0]  = prep_c.g[0] | (a_i[0] & prep_c.c0) | (prep_c.p[0] & prep_c.c0);
        prep_c.a_msb = a_i[WIDTH-1];
    end

    // Prefix levels spread evenly over the stages; stage s ends after level floor(L*(s+1)/S).
    for (genvar s = 0; s < STAGES; s++) begin : g_lvl
        localparam int unsigned LO = (LVLS * s) / STAGES;
        localparam int unsigned HI = (LVLS * (s + 1)) / STAGES;
        if (s == 0) begin : g_first
            assign nxt_c[s] = prefix_levels(prep_c, LO, HI);
        end else begin : g_rest
            assign nxt_c[s] = prefix_levels(st_q[s-1], LO, HI);
        end
    end

    // Valid bit feeding each stage: in_valid for stage 0, previous stage valid otherwise.
    if (STAGES == 1) begin : g_vin1
        assign vin_c = in_valid;
    end else begin : g_vinn
        assign vin_c = {v_q[STAGES-2:0], in_valid};
    end

    // Ready chain, stage advance and register next-state; flush clears valids only.
    always_comb begin
        rdy_c         = '0;
        v_d           = v_q;
        st_d          = st_q;
        rdy_c[STAGES] = out_ready;
        for (int s = int'(STAGES) - 1; s >= 0; s--) begin
            rdy_c[s] = ~v_q[s] | rdy_c[s+1];
        end
        for (int unsigned s = 0; s < STAGES; s++) begin
            if (flush_i) begin
                v_d[s] = 1'b0;
            end else if (rdy_c[s]) begin
                v_d[s] = vin_c[s];
                if (vin_c[s]) begin
                    st_d[s] = nxt_c[s];
                end
            end
        end
        in_ready = rdy_c[0] & ~flush_i;
    end

    // Stage valid and data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int unsigned s = 0; s < STAGES; s++) begin
                st_q[s] <= '0;
            end
        end else begin
            v_q  <= v_d;
            st_q <= st_d;
        end
    end

    assign last_c   = st_q[STAGES-1];
    assign unused_p = ^last_c.p;

    // Sum and flags from the final prefix carries.
    always_comb begin
        sum_c     = last_c.po ^ {last_c.g[WIDTH-2:0], last_c.c0};
        sum_o     = sum_c;
        cout_o    = last_c.g[WIDTH-1];
        ovf_o     = ~last_c.po[WIDTH-1] & (sum_c[WIDTH-1] ^ last_c.a_msb);
        zero_o    = (sum_c == '0);
        neg_o     = sum_c[WIDTH-1];
        out_valid = v_q[STAGES-1];
    end

endmodule

// File: tb/tb_adder_prefix_pipe.sv
// Bench for adder_prefix_pipe: four instances of different width/depth,
// scoreboarded against an arithmetic reference model.
module tb_adder_prefix_pipe;

    localparam int NI = 4;

    function automatic int unsigned w_of(input int j);
        return (j == 0) ? 32 : (j == 1) ? 8 : (j == 2) ? 16 : 64;
    endfunction

    function automatic int unsigned s_of(input int j);
        return (j == 0) ? 2 : (j == 1) ? 4 : (j == 2) ? 3 : 1;
    endfunction

    typedef struct packed {
        logic [63:0] s;
        logic        c;
        logic        o;
        logic        z;
        logic        n;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [63:0] a_x   [NI];
    logic [63:0] b_x   [NI];
    logic [63:0] sum_x [NI];
    logic        cin_x [NI];
    logic        sub_x [NI];
    logic        fl_x  [NI];
    logic        iv_x  [NI];
    logic        ir_x  [NI];
    logic        ov_x  [NI];
    logic        or_x  [NI];
    logic        co_x  [NI];
    logic        vf_x  [NI];
    logic        z_x   [NI];
    logic        n_x   [NI];

    exp_t        q_exp [NI][$];
    logic        stall_q [NI];
    logic        fl_q    [NI];
    logic [63:0] hold_s  [NI];
    logic [3:0]  hold_f  [NI];
    int          popped  [NI];
    int          n_chk;
    int          n_err;

    for (genvar j = 0; j < NI; j++) begin : g_dut
        localparam int unsigned W = w_of(j);
        localparam int unsigned S = s_of(j);
        logic [W-1:0] a_w;
        logic [W-1:0] b_w;
        logic [W-1:0] s_w;
        assign a_w      = a_x[j][W-1:0];
        assign b_w      = b_x[j][W-1:0];
        assign sum_x[j] = 64'(s_w);
        adder_prefix_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush_i  (fl_x[j]),
            .in_valid (iv_x[j]),
            .in_ready (ir_x[j]),
            .a_i      (a_w),
            .b_i      (b_w),
            .cin_i    (cin_x[j]),
            .sub_i    (sub_x[j]),
            .out_valid(ov_x[j]),
            .out_ready(or_x[j]),
            .sum_o    (s_w),
            .cout_o   (co_x[j]),
            .ovf_o    (vf_x[j]),
            .zero_o   (z_x[j]),
            .neg_o    (n_x[j])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mask(input int unsigned w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    // Reference: plain unsigned and signed arithmetic on wide integers.
    function automatic exp_t model(input int unsigned w, input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic sub);
        logic signed [67:0] ua, ub, sa, sb, c, ru, rs, lim;
        exp_t e;
        ua  = $signed({4'b0, a});
        ub  = $signed({4'b0, b});
        c   = $signed({67'b0, cin});
        sa  = ua;
        sb  = ub;
        if (a[w-1]) sa = ua - (68'sd1 <<< w);
        if (b[w-1]) sb = ub - (68'sd1 <<< w);
        ru  = sub ? (ua - ub - c) : (ua + ub + c);
        rs  = sub ? (sa - sb - c) : (sa + sb + c);
        lim = 68'sd1 <<< (w - 1);
        e.s = ru[63:0] & mask(w);
        e.c = sub ? (ru >= 0) : (ru >= (68'sd1 <<< w));
        e.o = (rs >= lim) || (rs < -lim);
        e.z = (e.s == 64'd0);
        e.n = e.s[w-1];
        return e;
    endfunction

    function automatic logic [63:0] pick(input int unsigned w);
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return mask(w);
            2:       return 64'd1 << (w - 1);
            3:       return mask(w) >> 1;
            default: return {$urandom(), $urandom()} & mask(w);
        endcase
    endfunction

    // Scoreboard: sampled 2 time units after the falling edge, once inputs are settled.
    always @(negedge clk) begin
        #2;
        for (int j = 0; j < NI; j++) begin
            if (!rst_n) begin
                chk($sformatf("u%0d_rst_valid", j), 64'(ov_x[j]), 64'd0);
                chk($sformatf("u%0d_rst_sum", j), sum_x[j], 64'd0);
                chk($sformatf("u%0d_rst_flags", j), 64'({co_x[j], vf_x[j], z_x[j], n_x[j]}), 64'b0010);
                q_exp[j].delete();
                stall_q[j] = 1'b0;
                fl_q[j]    = 1'b0;
            end else begin
                if (fl_q[j]) chk($sformatf("u%0d_flush_valid", j), 64'(ov_x[j]), 64'd0);
                if (stall_q[j]) begin
                    chk($sformatf("u%0d_hold_valid", j), 64'(ov_x[j]), 64'd1);
                    chk($sformatf("u%0d_hold_sum", j), sum_x[j], hold_s[j]);
                    chk($sformatf("u%0d_hold_flags", j), 64'({co_x[j], vf_x[j], z_x[j], n_x[j]}), 64'(hold_f[j]));
                end
                if (q_exp[j].size() == 0) begin
                    chk($sformatf("u%0d_idle_valid", j), 64'(ov_x[j]), 64'd0);
                end else if (ov_x[j] && or_x[j]) begin
                    exp_t e;
                    e = q_exp[j].pop_front();
                    popped[j]++;
                    chk($sformatf("u%0d_sum", j), sum_x[j], e.s);
                    chk($sformatf("u%0d_flags", j), 64'({co_x[j], vf_x[j], z_x[j], n_x[j]}),
                        64'({e.c, e.o, e.z, e.n}));
                end
                stall_q[j] = ov_x[j] && !or_x[j] && !fl_x[j];
                hold_s[j]  = sum_x[j];
                hold_f[j]  = {co_x[j], vf_x[j], z_x[j], n_x[j]};
                if (fl_x[j]) q_exp[j].delete();
                else if (iv_x[j] && ir_x[j])
                    q_exp[j].push_back(model(w_of(j), a_x[j], b_x[j], cin_x[j], sub_x[j]));
                fl_q[j] = fl_x[j];
            end
        end
    end

    // Present one beat on instance 0 (call at a falling edge); returns after it is taken.
    task automatic send0(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        int k;
        k        = 0;
        iv_x[0]  = 1'b1;
        a_x[0]   = 64'(a);
        b_x[0]   = 64'(b);
        cin_x[0] = cin;
        sub_x[0] = sub;
        #1;
        while (!ir_x[0] && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("send_accept", 64'(k < 100), 64'd1);
        @(negedge clk);
        iv_x[0] = 1'b0;
    endtask

    // Wait for the next result on instance 0 and compare against fixed values.
    task automatic expect0(input string tag, input logic [31:0] s, input logic [3:0] flags, output int lat);
        int k;
        k = 0;
        #2;
        while (!ov_x[0] && k < 20) begin
            @(negedge clk);
            #2;
            k++;
        end
        chk({tag, "_valid"}, 64'(ov_x[0]), 64'd1);
        chk({tag, "_sum"}, sum_x[0], 64'(s));
        chk({tag, "_flags"}, 64'({co_x[0], vf_x[0], z_x[0], n_x[0]}), 64'(flags));
        lat = k;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int base;
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b1;
        for (int j = 0; j < NI; j++) begin
            a_x[j] = '0; b_x[j] = '0; cin_x[j] = 1'b0; sub_x[j] = 1'b0;
            fl_x[j] = 1'b0; iv_x[j] = 1'b0; or_x[j] = 1'b1;
            stall_q[j] = 1'b0; fl_q[j] = 1'b0; popped[j] = 0;
            hold_s[j] = '0; hold_f[j] = '0;
        end
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready_after_rst", 64'(ir_x[0]), 64'd1);
        @(negedge clk);

        // Flags are {cout, ovf, zero, neg}; result appears in the second cycle after presentation.
        send0(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        expect0("t1", 32'h0, 4'b1010, lat);
        chk("t1_latency", 64'(lat), 64'd1);
        send0(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        expect0("t2a", 32'h8000_0000, 4'b0101, lat);
        send0(32'h8000_0000, 32'h1, 1'b0, 1'b1);
        expect0("t2b", 32'h7FFF_FFFF, 4'b1100, lat);
        send0(32'h5, 32'h7, 1'b0, 1'b1);
        expect0("t3a", 32'hFFFF_FFFE, 4'b0001, lat);
        send0(32'h7, 32'h5, 1'b1, 1'b1);
        expect0("t3b", 32'h1, 4'b1000, lat);

        // 20-beat stream with a 10-cycle consumer stall.
        base = popped[0];
        fork
            begin
                for (int i = 0; i < 20; i++)
                    send0($urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            begin
                repeat (5) @(negedge clk);
                or_x[0] = 1'b0;
                repeat (8) @(negedge clk);
                #2;
                chk("stall_in_ready", 64'(ir_x[0]), 64'd0);
                chk("stall_out_valid", 64'(ov_x[0]), 64'd1);
                repeat (2) @(negedge clk);
                or_x[0] = 1'b1;
            end
        join
        repeat (10) @(negedge clk);
        chk("stream_count", 64'(popped[0] - base), 64'd20);

        // Flush with a beat offered in the same cycle.
        or_x[0] = 1'b0;
        send0(32'h11, 32'h22, 1'b0, 1'b0);
        send0(32'h33, 32'h44, 1'b0, 1'b0);
        fl_x[0] = 1'b1; iv_x[0] = 1'b1; a_x[0] = 64'h55; b_x[0] = 64'h66;
        #1 chk("flush_in_ready", 64'(ir_x[0]), 64'd0);
        @(negedge clk);
        fl_x[0] = 1'b0; iv_x[0] = 1'b0; or_x[0] = 1'b1;
        #2 chk("flush_out_valid", 64'(ov_x[0]), 64'd0);
        @(negedge clk);
        send0(32'h100, 32'h23, 1'b1, 1'b0);
        expect0("after_flush", 32'h124, 4'b0000, lat);
        chk("after_flush_latency", 64'(lat), 64'd1);

        // Asynchronous reset in the middle of a stream.
        iv_x[0] = 1'b1; a_x[0] = 64'h1234; b_x[0] = 64'h1;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(ov_x[0]), 64'd0);
        chk("async_rst_sum", sum_x[0], 64'd0);
        chk("async_rst_zero", 64'(z_x[0]), 64'd1);
        iv_x[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("async_rst_ready", 64'(ir_x[0]), 64'd1);
        @(negedge clk);
        send0(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        expect0("after_rst", 32'hFFFF_FFFE, 4'b1001, lat);

        // Random traffic on all instances with random stalls and rare flushes.
        for (int cyc = 0; cyc < 5000; cyc++) begin
            @(negedge clk);
            for (int j = 0; j < NI; j++) begin
                iv_x[j]  = ($urandom_range(0, 99) < 70);
                a_x[j]   = pick(w_of(j));
                b_x[j]   = pick(w_of(j));
                cin_x[j] = 1'($urandom_range(0, 1));
                sub_x[j] = 1'($urandom_range(0, 1));
                or_x[j]  = ($urandom_range(0, 99) < 75);
                fl_x[j]  = ($urandom_range(0, 299) == 0);
            end
        end
        @(negedge clk);
        for (int j = 0; j < NI; j++) begin
            iv_x[j] = 1'b0; or_x[j] = 1'b1; fl_x[j] = 1'b0;
        end
        repeat (20) @(negedge clk);
        #3;
        for (int j = 0; j < NI; j++) begin
            chk($sformatf("u%0d_drain", j), 64'(q_exp[j].size()), 64'd0);
            chk($sformatf("u%0d_drain_valid", j), 64'(ov_x[j]), 64'd0);
            chk($sformatf("u%0d_beats_seen", j), 64'(popped[j] > 1000), 64'd1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
